atm_session_driver: RTL and testbench

//  Initiator-side front end for the ATM core: accepts one customer command per handshake (login,

---
 rtl/atm_pkg.sv | 44 ++++
 rtl/atm_hold_timer.sv | 26 ++
 rtl/atm_session_driver.sv | 203 ++++++++++++++++++++
 tb/tb_atm_session_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session driver: command ops, response status and
// the ATM core's menuOption codes.
package atm_pkg;

  typedef enum logic [2:0] {
    OP_LOGIN         = 3'd0,
    OP_BALANCE       = 3'd1,
    OP_WITHDRAW      = 3'd2,
    OP_WITHDRAW_SHOW = 3'd3,
    OP_TRANSFER      = 3'd4,
    OP_LOGOUT        = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    ST_OK             = 3'd0,
    ST_AUTH_FAIL      = 3'd1,
    ST_ATM_ERROR      = 3'd2,
    ST_NOT_LOGGED_IN  = 3'd3,
    ST_SESSION_ACTIVE = 3'd4,
    ST_AMOUNT_RANGE   = 3'd5
  } status_e;

  localparam logic [2:0] MENU_WAITING       = 3'b000;
  localparam logic [2:0] MENU_BALANCE       = 3'b001;
  localparam logic [2:0] MENU_WITHDRAW      = 3'b010;
  localparam logic [2:0] MENU_PIN_OK        = 3'b011;
  localparam logic [2:0] MENU_SELECT        = 3'b100;
  localparam logic [2:0] MENU_WITHDRAW_SHOW = 3'b101;
  localparam logic [2:0] MENU_TRANSFER      = 3'b110;
  localparam logic [2:0] MENU_DONE          = 3'b111;

  localparam int MAX_AMOUNT_DEFAULT = 2047;

  function automatic logic [2:0] menu_for(input op_e op);
    case (op)
      OP_BALANCE:       return MENU_BALANCE;
      OP_WITHDRAW:      return MENU_WITHDRAW;
      OP_WITHDRAW_SHOW: return MENU_WITHDRAW_SHOW;
      OP_TRANSFER:      return MENU_TRANSFER;
      default:          return MENU_WAITING;
    endcase
  endfunction

endpackage

// File: rtl/atm_hold_timer.sv
// Loadable down-counter that stops at 1; done marks the last cycle of a window.
module atm_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg > WIDTH'(1)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == WIDTH'(1));

endmodule

// File: rtl/atm_session_driver.sv
// Terminal-side front end for the ATM core: one command at a time is turned into
// a timed sequence on the ATM request pins, then a single response is returned.
module atm_session_driver
  import atm_pkg::*;
#(
  parameter int LOGIN_HOLD = 4,
  parameter int RESP_WAIT  = 3,
  parameter int EXIT_HOLD  = 2,
  parameter int MAX_AMOUNT = MAX_AMOUNT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_acc,
  input  logic [3:0]  cmd_pin,
  input  logic [11:0] cmd_dest,
  input  logic [11:0] cmd_amount,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [2:0]  resp_status,
  output logic [10:0] resp_balance,
  output logic        logged_in,
  output logic [11:0] atm_acc_number,
  output logic [3:0]  atm_pin,
  output logic [11:0] atm_dest,
  output logic [2:0]  atm_menu_option,
  output logic [10:0] atm_amount,
  output logic        atm_exit,
  output logic        atm_step,
  input  logic        atm_error,
  input  logic [10:0] atm_balance
);

  typedef enum logic [2:0] {
    IDLE, LOGIN_HOLD_S, DRIVE, STEP, WAIT, EXIT_HI, EXIT_LO, RESPOND
  } state_e;

  state_e      state_reg, state_next;
  logic        logged_in_reg;
  logic [11:0] acc_reg, dest_reg;
  logic [3:0]  pin_reg;
  logic [2:0]  menu_reg;
  logic [10:0] amount_reg, balance_reg;
  logic        exit_reg;
  status_e     status_reg;

  op_e         op;
  logic        amount_op;
  logic        reject;
  status_e     reject_status;
  logic        timer_load;
  logic [7:0]  timer_value;
  logic        timer_done;

  atm_hold_timer #(.WIDTH(8)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Decide locally rejected commands before any ATM pin moves.
  always_comb begin
    op            = op_e'(cmd_op);
    amount_op     = (op == OP_WITHDRAW) || (op == OP_WITHDRAW_SHOW) || (op == OP_TRANSFER);
    reject        = 1'b0;
    reject_status = ST_OK;
    if (op == OP_LOGIN) begin
      if (logged_in_reg) begin
        reject        = 1'b1;
        reject_status = ST_SESSION_ACTIVE;
      end
    end else if (!logged_in_reg) begin
      reject        = 1'b1;
      reject_status = ST_NOT_LOGGED_IN;
    end else if (amount_op && (cmd_amount > 12'(MAX_AMOUNT))) begin
      reject        = 1'b1;
      reject_status = ST_AMOUNT_RANGE;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          if (reject) begin
            state_next = RESPOND;
          end else if (op == OP_LOGIN) begin
            state_next  = LOGIN_HOLD_S;
            timer_load  = 1'b1;
            timer_value = 8'(LOGIN_HOLD);
          end else if (op == OP_LOGOUT) begin
            state_next  = EXIT_HI;
            timer_load  = 1'b1;
            timer_value = 8'(EXIT_HOLD);
          end else begin
            state_next = DRIVE;
          end
        end
      end
      LOGIN_HOLD_S: if (timer_done) state_next = RESPOND;
      DRIVE:        state_next = STEP;
      STEP: begin
        state_next  = WAIT;
        timer_load  = 1'b1;
        timer_value = 8'(RESP_WAIT);
      end
      WAIT:         if (timer_done) state_next = RESPOND;
      EXIT_HI:      if (timer_done) state_next = EXIT_LO;
      EXIT_LO:      state_next = RESPOND;
      RESPOND:      if (resp_ready) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      logged_in_reg <= 1'b0;
      acc_reg       <= '0;
      pin_reg       <= '0;
      dest_reg      <= '0;
      menu_reg      <= MENU_WAITING;
      amount_reg    <= '0;
      exit_reg      <= 1'b0;
      status_reg    <= ST_OK;
      balance_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            if (reject) begin
              status_reg  <= reject_status;
              balance_reg <= '0;
            end else if (op == OP_LOGIN) begin
              acc_reg <= cmd_acc;
              pin_reg <= cmd_pin;
            end else if (op == OP_LOGOUT) begin
              exit_reg <= 1'b1;
            end else begin
              menu_reg   <= menu_for(op);
              amount_reg <= amount_op ? cmd_amount[10:0] : '0;
              dest_reg   <= (op == OP_TRANSFER) ? cmd_dest : '0;
            end
          end
        end
        LOGIN_HOLD_S: begin
          if (timer_done) begin
            if (atm_error) begin
              status_reg  <= ST_AUTH_FAIL;
              balance_reg <= '0;
              acc_reg     <= '0;
              pin_reg     <= '0;
            end else begin
              status_reg    <= ST_OK;
              balance_reg   <= atm_balance;
              logged_in_reg <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (timer_done) begin
            status_reg  <= atm_error ? ST_ATM_ERROR : ST_OK;
            balance_reg <= atm_balance;
            menu_reg    <= MENU_WAITING;
            amount_reg  <= '0;
            dest_reg    <= '0;
          end
        end
        EXIT_HI: if (timer_done) exit_reg <= 1'b0;
        EXIT_LO: begin
          logged_in_reg <= 1'b0;
          acc_reg       <= '0;
          pin_reg       <= '0;
          status_reg    <= ST_OK;
          balance_reg   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready       = (state_reg == IDLE);
  assign resp_valid      = (state_reg == RESPOND);
  assign resp_status     = status_reg;
  assign resp_balance    = balance_reg;
  assign logged_in       = logged_in_reg;
  assign atm_acc_number  = acc_reg;
  assign atm_pin         = pin_reg;
  assign atm_dest        = dest_reg;
  assign atm_menu_option = menu_reg;
  assign atm_amount      = amount_reg;
  assign atm_exit        = exit_reg;
  assign atm_step        = (state_reg == STEP);

endmodule

// File: tb/tb_atm_session_driver.sv
// Directed bench for atm_session_driver; the ATM core is stood in for by
// directly driven atm_error/atm_balance values.
module tb_atm_session_driver;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_acc;
  logic [3:0]  cmd_pin;
  logic [11:0] cmd_dest;
  logic [11:0] cmd_amount;
  logic        resp_valid;
  logic        resp_ready;
  logic [2:0]  resp_status;
  logic [10:0] resp_balance;
  logic        logged_in;
  logic [11:0] atm_acc_number;
  logic [3:0]  atm_pin;
  logic [11:0] atm_dest;
  logic [2:0]  atm_menu_option;
  logic [10:0] atm_amount;
  logic        atm_exit;
  logic        atm_step;
  logic        atm_error;
  logic [10:0] atm_balance;

  int checks = 0;
  int failures = 0;

  // Per-transaction observations
  int          lat, steps, exits;
  logic [2:0]  step_menu;
  logic [10:0] step_amt;
  logic [11:0] step_dest;
  logic [11:0] acc0;
  int          seen;

  always #5 clk = ~clk;

  atm_session_driver dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_acc         (cmd_acc),
    .cmd_pin         (cmd_pin),
    .cmd_dest        (cmd_dest),
    .cmd_amount      (cmd_amount),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_status     (resp_status),
    .resp_balance    (resp_balance),
    .logged_in       (logged_in),
    .atm_acc_number  (atm_acc_number),
    .atm_pin         (atm_pin),
    .atm_dest        (atm_dest),
    .atm_menu_option (atm_menu_option),
    .atm_amount      (atm_amount),
    .atm_exit        (atm_exit),
    .atm_step        (atm_step),
    .atm_error       (atm_error),
    .atm_balance     (atm_balance)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command, then sample #1 after each edge until resp_valid (bounded).
  task automatic run(input op_e op, input logic [11:0] acc, input logic [3:0] pin,
                     input logic [11:0] dest, input logic [11:0] amt);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_acc = acc; cmd_pin = pin;
    cmd_dest = dest; cmd_amount = amt;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_acc = '0; cmd_pin = '0; cmd_dest = '0; cmd_amount = '0;
    lat = 0; steps = 0; exits = 0; acc0 = atm_acc_number;
    step_menu = '0; step_amt = '0; step_dest = '0;
    while (!resp_valid && lat < 40) begin
      if (atm_step) begin
        steps++; step_menu = atm_menu_option; step_amt = atm_amount; step_dest = atm_dest;
      end
      if (atm_exit) exits++;
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    $display("txn op=%0d lat=%0d status=%0d balance=%0d logged_in=%0d steps=%0d",
             op, lat, resp_status, resp_balance, logged_in, steps);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_acc = '0; cmd_pin = '0;
    cmd_dest = '0; cmd_amount = '0; resp_ready = 1'b0; atm_error = 1'b0; atm_balance = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_logged_in", 32'(logged_in), 32'd0);
    check("reset_menu", 32'(atm_menu_option), 32'(MENU_WAITING));

    // 1: failed authentication
    atm_error = 1'b1;
    run(OP_LOGIN, 12'd2278, 4'b0100, 12'd0, 12'd0);
    check("t1_acc_driven", 32'(acc0), 32'd2278);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_status", 32'(resp_status), 32'(ST_AUTH_FAIL));
    check("t1_logged_in", 32'(logged_in), 32'd0);
    ack();
    check("t1_ready_after_ack", 32'(cmd_ready), 32'd1);

    // 2: good login, then withdraw-and-show
    atm_error = 1'b0; atm_balance = 11'd500;
    run(OP_LOGIN, 12'd2178, 4'b0100, 12'd0, 12'd0);
    check("t2_login_lat", 32'(lat), 32'd4);
    check("t2_login_status", 32'(resp_status), 32'(ST_OK));
    check("t2_login_balance", 32'(resp_balance), 32'd500);
    check("t2_logged_in", 32'(logged_in), 32'd1);
    ack();
    atm_balance = 11'd400;
    run(OP_WITHDRAW_SHOW, 12'd0, 4'd0, 12'd0, 12'd100);
    check("t2_steps", 32'(steps), 32'd1);
    check("t2_menu", 32'(step_menu), 32'd5);
    check("t2_amount", 32'(step_amt), 32'd100);
    check("t2_lat", 32'(lat), 32'd5);
    check("t2_status", 32'(resp_status), 32'(ST_OK));
    check("t2_balance", 32'(resp_balance), 32'd400);
    check("t2_menu_idle", 32'(atm_menu_option), 32'(MENU_WAITING));
    ack();

    // 3: amount over range, then balance
    run(OP_WITHDRAW, 12'd0, 4'd0, 12'd0, 12'd2500);
    check("t3_lat", 32'(lat), 32'd0);
    check("t3_status", 32'(resp_status), 32'(ST_AMOUNT_RANGE));
    check("t3_steps", 32'(steps), 32'd0);
    ack();
    run(OP_BALANCE, 12'd0, 4'd0, 12'd0, 12'd0);
    check("t3_bal_status", 32'(resp_status), 32'(ST_OK));
    check("t3_bal_balance", 32'(resp_balance), 32'd400);
    check("t3_bal_menu", 32'(step_menu), 32'd1);
    ack();

    // 4: transfer, then an ATM-side error
    atm_balance = 11'd350;
    run(OP_TRANSFER, 12'd0, 4'd0, 12'd2816, 12'd50);
    check("t4_dest", 32'(step_dest), 32'd2816);
    check("t4_menu", 32'(step_menu), 32'd6);
    check("t4_amount", 32'(step_amt), 32'd50);
    check("t4_status", 32'(resp_status), 32'(ST_OK));
    check("t4_balance", 32'(resp_balance), 32'd350);
    ack();
    atm_error = 1'b1;
    run(OP_BALANCE, 12'd0, 4'd0, 12'd0, 12'd0);
    check("t4_err_status", 32'(resp_status), 32'(ST_ATM_ERROR));
    check("t4_err_balance", 32'(resp_balance), 32'd350);
    ack();
    atm_error = 1'b0;

    // 5: logout, rejected balance, new login
    run(OP_LOGOUT, 12'd0, 4'd0, 12'd0, 12'd0);
    check("t5_exit_cycles", 32'(exits), 32'd2);
    check("t5_lat", 32'(lat), 32'd3);
    check("t5_status", 32'(resp_status), 32'(ST_OK));
    check("t5_balance", 32'(resp_balance), 32'd0);
    check("t5_logged_in", 32'(logged_in), 32'd0);
    check("t5_acc_cleared", 32'(atm_acc_number), 32'd0);
    ack();
    run(OP_BALANCE, 12'd0, 4'd0, 12'd0, 12'd0);
    check("t5_nli_lat", 32'(lat), 32'd0);
    check("t5_nli_status", 32'(resp_status), 32'(ST_NOT_LOGGED_IN));
    ack();
    atm_balance = 11'd900;
    run(OP_LOGIN, 12'd2816, 4'b0110, 12'd0, 12'd0);
    check("t5_login_status", 32'(resp_status), 32'(ST_OK));
    check("t5_login_pin", 32'(atm_pin), 32'd6);
    check("t5_logged_in2", 32'(logged_in), 32'd1);
    ack();
    run(OP_LOGIN, 12'd100, 4'd1, 12'd0, 12'd0);
    check("t5_session_active", 32'(resp_status), 32'(ST_SESSION_ACTIVE));
    ack();

    // 6: back-pressure on the response, then reset mid-WAIT
    run(OP_BALANCE, 12'd0, 4'd0, 12'd0, 12'd0);
    cmd_valid = 1'b1; cmd_op = OP_LOGOUT;
    repeat (10) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t6_hold_valid", 32'(resp_valid), 32'd1);
    check("t6_hold_status", 32'(resp_status), 32'(ST_OK));
    check("t6_hold_balance", 32'(resp_balance), 32'd900);
    check("t6_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    check("t6_hold_logged_in", 32'(logged_in), 32'd1);
    ack();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_BALANCE;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_logged_in", 32'(logged_in), 32'd0);
    check("t6_rst_menu", 32'(atm_menu_option), 32'd0);
    check("t6_rst_step", 32'(atm_step), 32'd0);
    check("t6_rst_exit", 32'(atm_exit), 32'd0);
    check("t6_rst_acc", 32'(atm_acc_number), 32'd0);
    check("t6_rst_balance", 32'(resp_balance), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    check("t6_rst_no_resp", 32'(seen), 32'd0);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
